down_timer: RTL and testbench
=============================

DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 The block SHALL have parameter N, default 6, giving the counter width in bits.
REQ-002 The block SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-003 The block SHALL have port clr, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port load, input, 1, load and start request, sampled per cycle.
REQ-005 The block SHALL have port din, input, N, start value captured on load.
REQ-006 The block SHALL have port en, input, 1, count enable.
REQ-007 The block SHALL have port rld, input, 1, auto-reload mode select, captured on load.
REQ-008 The block SHALL have port abort, input, 1, synchronous stop request.
REQ-009 The block SHALL have port q, output, N, current count value.
REQ-010 The block SHALL have port busy, output, 1, high in states RUN and PAUSE.
REQ-011 The block SHALL have port done, output, 1, high in state EXPIRED.
REQ-012 The block SHALL have port tc, output, 1, registered one-cycle terminal-count pulse.

Function
REQ-013 The block SHALL implement states IDLE, RUN, PAUSE and EXPIRED.
REQ-014 The block SHALL give inputs this per-edge priority: abort, then load, then count/enable.
REQ-015 abort SHALL, from any state, set q=0, next state IDLE, and tc=0 in the following cycle.
REQ-016 When load=1 and din!=0, the block SHALL, in any state, set q=din, capture din as reload value R, capture rld as mode M, and enter RUN; counting of any prior load is discarded.
REQ-017 When load=1 and din=0, the block SHALL set q=0, enter IDLE and produce no tc.
REQ-018 In RUN with en=0, the block SHALL move to PAUSE with q held.
REQ-019 In PAUSE with en=1, the block SHALL return to RUN and decrement on the same edge.
REQ-020 In RUN or PAUSE with en=1 and q>1, the block SHALL set q=q-1 and stay in or enter RUN.
REQ-021 With en=1, q=1 and M=0 (one-shot), the block SHALL set q=0, enter EXPIRED and set tc=1 for exactly the next cycle.
REQ-022 With en=1, q=1 and M=1 (auto-reload), the block SHALL set q=R, stay in RUN and set tc=1 for exactly the next cycle, giving a tc period of R enabled cycles.
REQ-023 q SHALL never wrap from 0 to all-ones; en has no effect in IDLE or EXPIRED.
REQ-024 In EXPIRED, q SHALL hold 0 and done SHALL hold 1 until load or abort.
REQ-025 Latency SHALL be one edge from load to q=din/busy=1; the first decrement SHALL occur on the following edge with en=1.
REQ-026 With load=1 and en=1 on the same edge, the block SHALL only load and not decrement.
REQ-027 tc SHALL be 0 in every cycle not covered by REQ-021 or REQ-022.
REQ-028 A load coinciding with the terminal edge SHALL win: q=din, and no tc is produced.
REQ-029 All outputs SHALL be registered or decoded from registered state only, with no combinational input-to-output path.

Reset
REQ-030 While clr=1, the block SHALL force IDLE, q=0, R=0, M=0, busy=0, done=0 and tc=0, immediately and independent of clk.
REQ-031 Deassertion of clr SHALL leave IDLE; the first load is accepted on the first subsequent edge.
REQ-032 Asserting clr mid-count SHALL discard state with no tc pulse.

Verification
REQ-033 Reset, then N=6, load din=5 rld=0, en=1 -> q 5,4,3,2,1,0; tc high one cycle with q=0; done=1, busy=0; q stays 0 for 10 further cycles.
REQ-034 Load din=3 rld=1, en=1 held 12 cycles -> q 3,2,1,3,2,1,...; tc pulses every 3 cycles; busy stays 1; done never 1.
REQ-035 Load din=4, en toggled 1,0,0,1,1,1 -> q 4,3,3,3,2,1,0; state PAUSE during en=0; one tc.
REQ-036 Load din=63 at the edge where q goes 1->0 -> q=63, no tc, RUN; abort at q=40 -> q=0, IDLE, no tc.
REQ-037 Load din=0 -> q=0, IDLE, busy=0, no tc; clr pulse mid-count at q=20 -> q=0 asynchronously, no tc afterwards.

Source files
------------

// File: rtl/down_timer.sv
// Loadable down-counter with pause, one-shot / auto-reload modes and a
// registered terminal-count pulse. All outputs come straight from flops or state decode.
module down_timer #(
  parameter int N = 6
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] din,
  input  logic         en,
  input  logic         rld,
  input  logic         abort,
  output logic [N-1:0] q,
  output logic         busy,
  output logic         done,
  output logic         tc
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] rval_q, rval_d;
  logic         mode_q, mode_d;
  logic         tc_q, tc_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= ZERO;
      rval_q  <= ZERO;
      mode_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rval_q  <= rval_d;
      mode_q  <= mode_d;
      tc_q    <= tc_d;
    end
  end

  // Priority: abort, then load, then the enabled count step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rval_d  = rval_q;
    mode_d  = mode_q;
    tc_d    = 1'b0;

    if (abort) begin
      state_d = IDLE;
      cnt_d   = ZERO;
    end else if (load) begin
      if (din != ZERO) begin
        state_d = RUN;
        cnt_d   = din;
        rval_d  = din;
        mode_d  = rld;
      end else begin
        state_d = IDLE;
        cnt_d   = ZERO;
      end
    end else begin
      unique case (state_q)
        RUN, PAUSE: begin
          if (!en) begin
            state_d = PAUSE;
          end else if (cnt_q > ONE) begin
            state_d = RUN;
            cnt_d   = cnt_q - ONE;
          end else if (cnt_q == ONE) begin
            tc_d = 1'b1;
            if (mode_q) begin
              state_d = RUN;
              cnt_d   = rval_q;
            end else begin
              state_d = EXPIRED;
              cnt_d   = ZERO;
            end
          end else begin
            // A zero count while active is unreachable; park safely without wrapping.
            state_d = IDLE;
            cnt_d   = ZERO;
          end
        end
        EXPIRED: cnt_d = ZERO;
        default: ;
      endcase
    end
  end

  assign q    = cnt_q;
  assign busy = (state_q == RUN) || (state_q == PAUSE);
  assign done = (state_q == EXPIRED);
  assign tc   = tc_q;

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: stimulus pushes hand-computed expectations,
// a monitor pops one per clock shortly after the rising edge and compares.
module tb_down_timer;

  localparam int N = 6;

  logic         clk = 1'b0;
  logic         clr;
  logic         load;
  logic [N-1:0] din;
  logic         en;
  logic         rld;
  logic         abort;
  logic [N-1:0] q;
  logic         busy;
  logic         done;
  logic         tc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [N-1:0] q;
    logic         busy;
    logic         done;
    logic         tc;
    string        name;
  } exp_t;

  exp_t sb[$];

  down_timer #(.N(N)) dut (
    .clk   (clk),
    .clr   (clr),
    .load  (load),
    .din   (din),
    .en    (en),
    .rld   (rld),
    .abort (abort),
    .q     (q),
    .busy  (busy),
    .done  (done),
    .tc    (tc)
  );

  always #5 clk = ~clk;

  task automatic compare(input exp_t e);
    checks++;
    if (q !== e.q || busy !== e.busy || done !== e.done || tc !== e.tc) begin
      errors++;
      $display("FAIL %s: got q=%0d busy=%b done=%b tc=%b, want q=%0d busy=%b done=%b tc=%b",
               e.name, q, busy, done, tc, e.q, e.busy, e.done, e.tc);
    end
  endtask

  // Drive one cycle of inputs and queue what the outputs must be after the next edge.
  task automatic step(input logic l, input logic [N-1:0] d, input logic e, input logic r,
                      input logic a, input logic [N-1:0] eq, input logic eb,
                      input logic ed, input logic et, input string nm);
    exp_t x;
    @(negedge clk);
    load = l; din = d; en = e; rld = r; abort = a;
    x.q = eq; x.busy = eb; x.done = ed; x.tc = et; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic count(input logic e, input logic [N-1:0] eq, input logic eb,
                       input logic ed, input logic et, input string nm);
    step(1'b0, '0, e, 1'b0, 1'b0, eq, eb, ed, et, nm);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #3;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        compare(x);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #4;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin : stim
    exp_t x;
    logic [N-1:0] v;
    clr = 1'b1; load = 0; din = '0; en = 0; rld = 0; abort = 0;
    #3;
    x.q = '0; x.busy = 0; x.done = 0; x.tc = 0; x.name = "reset";
    compare(x);
    @(negedge clk);
    clr = 1'b0;

    // One-shot from 5.
    step(1, 6'd5, 1, 0, 0, 6'd5, 1, 0, 0, "oneshot_load");
    for (int i = 4; i >= 1; i--) begin
      v = 6'(i);
      count(1, v, 1, 0, 0, "oneshot_dec");
    end
    count(1, 6'd0, 0, 1, 1, "oneshot_tc");
    for (int i = 0; i < 10; i++) count(1, 6'd0, 0, 1, 0, "expired_hold");

    // Auto-reload with R=3: tc on each reload to 3.
    step(1, 6'd3, 1, 1, 0, 6'd3, 1, 0, 0, "reload_load");
    for (int i = 0; i < 4; i++) begin
      count(1, 6'd2, 1, 0, 0, "reload_2");
      count(1, 6'd1, 1, 0, 0, "reload_1");
      count(1, 6'd3, 1, 0, 1, "reload_tc");
    end

    // Pause/resume.
    step(1, 6'd4, 1, 0, 0, 6'd4, 1, 0, 0, "pause_load");
    count(1, 6'd3, 1, 0, 0, "pause_run");
    count(0, 6'd3, 1, 0, 0, "pause_hold1");
    count(0, 6'd3, 1, 0, 0, "pause_hold2");
    count(1, 6'd2, 1, 0, 0, "pause_resume");
    count(1, 6'd1, 1, 0, 0, "pause_dec");
    count(1, 6'd0, 0, 1, 1, "pause_tc");

    // Load on the terminal edge wins, then abort beats a coincident load.
    step(1, 6'd2, 1, 0, 0, 6'd2, 1, 0, 0, "term_load2");
    count(1, 6'd1, 1, 0, 0, "term_at1");
    step(1, 6'd63, 1, 0, 0, 6'd63, 1, 0, 0, "term_load63");
    for (int i = 62; i >= 40; i--) begin
      v = 6'(i);
      count(1, v, 1, 0, 0, "run63_dec");
    end
    step(1, 6'd7, 1, 0, 1, 6'd0, 0, 0, 0, "abort");
    count(1, 6'd0, 0, 0, 0, "idle_en");

    // din=0 load from RUN goes idle, no wrap afterwards.
    step(1, 6'd9, 0, 0, 0, 6'd9, 1, 0, 0, "zl_load9");
    step(1, 6'd0, 1, 0, 0, 6'd0, 0, 0, 0, "zl_load0");
    count(1, 6'd0, 0, 0, 0, "zl_nowrap");

    // Asynchronous clear mid-count at q=20.
    step(1, 6'd30, 1, 0, 0, 6'd30, 1, 0, 0, "clr_load30");
    for (int i = 29; i >= 20; i--) begin
      v = 6'(i);
      count(1, v, 1, 0, 0, "clr_dec");
    end
    drain();
    @(negedge clk);
    en = 1'b1; load = 0;
    #2 clr = 1'b1;
    #1;
    x.q = '0; x.busy = 0; x.done = 0; x.tc = 0; x.name = "clr_async";
    compare(x);
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 3; i++) count(1, 6'd0, 0, 0, 0, "clr_after");
    // First load after clear accepted immediately.
    step(1, 6'd1, 1, 0, 0, 6'd1, 1, 0, 0, "post_clr_load");
    count(1, 6'd0, 0, 1, 1, "post_clr_tc");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
